// File: rtl/framebuffer_multi.sv
// framebuffer_multi: NBUF rotating frame buffers with a single draw and display port.
// Define FB_CLEAR_EN to clear each new draw buffer to CLR_COLR before it is writable.
module framebuffer_multi #(
  parameter int WIDTH = 4,
  parameter int HRES = 320,
  parameter int VRES = 240,
  parameter int NBUF = 2,
  parameter logic [WIDTH-1:0] CLR_COLR = '0,
  localparam int DEPTH = HRES * VRES,
  localparam int ADDRW = $clog2(DEPTH),
  localparam int BUFW = (NBUF > 2) ? $clog2(NBUF) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             we,
  input  logic [ADDRW-1:0] addr_write,
  input  logic [WIDTH-1:0] din,
  input  logic             draw_done,
  input  logic [ADDRW-1:0] addr_disp,
  output logic [WIDTH-1:0] dout_disp,
  output logic             busy,
  output logic             draw_ready,
  output logic [BUFW-1:0]  buf_draw,
  output logic [BUFW-1:0]  buf_disp,
  output logic             frame_repeat
);

  typedef enum logic [1:0] {S_CLEAR, S_READY, S_WAIT} state_t;

`ifdef FB_CLEAR_EN
  localparam state_t S_FILL = S_CLEAR;
  localparam logic RST_RDY = 1'b0;
`else
  localparam state_t S_FILL = S_READY;
  localparam logic RST_RDY = 1'b1;
`endif

  localparam logic [1:0] PMAX = 2'(NBUF - 2);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [NBUF][DEPTH];

  state_t           r_state, w_state_n;
  logic [BUFW-1:0]  r_disp, w_disp_n;
  logic [BUFW-1:0]  r_draw, w_draw_n;
  logic [1:0]       r_pend, w_pend_f, w_pend_n;
  logic [ADDRW-1:0] r_clr, w_clr_n;
  logic             r_rep, w_rep_n;
  logic             r_rdy;
  logic [WIDTH-1:0] r_dout;

  function automatic logic [BUFW-1:0] f_inc(input logic [BUFW-1:0] x);
    return (x == BUFW'(NBUF - 1)) ? '0 : x + BUFW'(1);
  endfunction

  // frame acts on the old pending count first, then draw_done sees the result
  always_comb begin
    w_disp_n  = r_disp;
    w_pend_f  = r_pend;
    w_rep_n   = 1'b0;
    if (frame) begin
      if (r_pend != 2'd0) begin
        w_disp_n = f_inc(r_disp);
        w_pend_f = r_pend - 2'd1;
      end else begin
        w_rep_n = 1'b1;
      end
    end
    w_pend_n  = w_pend_f;
    w_draw_n  = r_draw;
    w_state_n = r_state;
    w_clr_n   = r_clr;
    case (r_state)
      S_CLEAR: begin
        w_clr_n = r_clr + ADDRW'(1);
        if (r_clr == LAST) begin
          w_clr_n   = '0;
          w_state_n = S_READY;
        end
      end
      S_READY: begin
        if (draw_done) begin
          w_pend_n = w_pend_f + 2'd1;
          if (w_pend_n <= PMAX) begin
            w_draw_n  = f_inc(r_draw);
            w_state_n = S_FILL;
          end else begin
            w_state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_pend_f <= PMAX) begin
          w_draw_n  = f_inc(r_draw);
          w_state_n = S_FILL;
        end
      end
      default: w_state_n = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_disp  <= '0;
      r_draw  <= BUFW'(1);
      r_pend  <= '0;
      r_clr   <= '0;
      r_rep   <= 1'b0;
      r_rdy   <= RST_RDY;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_n;
      r_disp  <= w_disp_n;
      r_draw  <= w_draw_n;
      r_pend  <= w_pend_n;
      r_clr   <= w_clr_n;
      r_rep   <= w_rep_n;
      r_rdy   <= (w_state_n == S_READY);
      if (int'(addr_disp) < DEPTH)
        r_dout <= r_mem[r_disp][addr_disp];
      else
        r_dout <= '0;
    end
  end

  // memory has no reset; rst only blocks writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR)
        r_mem[r_draw][r_clr] <= CLR_COLR;
      else if (we && r_state == S_READY && int'(addr_write) < DEPTH)
        r_mem[r_draw][addr_write] <= din;
    end
  end

`ifdef FB_CLEAR_EN
  logic r_busy;
  always_ff @(posedge clk) begin
    if (rst) r_busy <= 1'b1;
    else     r_busy <= (w_state_n == S_CLEAR);
  end
  assign busy = r_busy;
`else
  assign busy = 1'b0;
`endif

  assign draw_ready   = r_rdy;
  assign dout_disp    = r_dout;
  assign buf_draw     = r_draw;
  assign buf_disp     = r_disp;
  assign frame_repeat = r_rep;

endmodule

// File: tb/tb_framebuffer_multi.sv
// tb_framebuffer_multi: NBUF=2 and NBUF=3 instances checked against a queue-based model.
// Directed steps first, then randomized traffic.
module tb_framebuffer_multi;

`ifdef FB_CLEAR_EN
  localparam int CLRN = 8;
`else
  localparam int CLRN = 0;
`endif

  logic clk = 1'b0;
  logic rst, frame, we, draw_done;
  logic [2:0] addr_write, addr_disp;
  logic [3:0] din;
  logic [3:0] dout0, dout1;
  logic busy0, busy1, rdy0, rdy1, rep0, rep1;
  logic [0:0] bd0, bs0;
  logic [1:0] bd1, bs1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  framebuffer_multi #(.WIDTH(4), .HRES(4), .VRES(2), .NBUF(2)) u0 (
    .clk(clk), .rst(rst), .frame(frame), .we(we),
    .addr_write(addr_write), .din(din), .draw_done(draw_done),
    .addr_disp(addr_disp), .dout_disp(dout0), .busy(busy0),
    .draw_ready(rdy0), .buf_draw(bd0), .buf_disp(bs0),
    .frame_repeat(rep0)
  );

  framebuffer_multi #(.WIDTH(4), .HRES(4), .VRES(2), .NBUF(3)) u1 (
    .clk(clk), .rst(rst), .frame(frame), .we(we),
    .addr_write(addr_write), .din(din), .draw_done(draw_done),
    .addr_disp(addr_disp), .dout_disp(dout1), .busy(busy1),
    .draw_ready(rdy1), .buf_draw(bd1), .buf_disp(bs1),
    .frame_repeat(rep1)
  );

  // model: pending buffers as an ordered list, clear as a countdown
  int m_mem [2][4][8];
  bit m_val [2][4][8];
  int m_D [2];
  int m_W [2];
  int m_pq [2][4];
  int m_pn [2];
  int m_clr [2];
  bit m_wait [2];
  bit m_rep [2];
  int m_dout [2];
  bit m_dval [2];

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_draw(input int k);
    m_W[k] = (m_W[k] + 1) % (k + 2);
    m_clr[k] = CLRN;
  endtask

  task automatic model_tick(input int k);
    int nb;
    bit ready;
    nb = k + 2;
    if (rst) begin
      m_D[k] = 0; m_W[k] = 1; m_pn[k] = 0; m_clr[k] = CLRN;
      m_wait[k] = 0; m_rep[k] = 0; m_dout[k] = 0; m_dval[k] = 1;
      return;
    end
    ready = (m_clr[k] == 0) && !m_wait[k];
    m_dout[k] = m_mem[k][m_D[k]][addr_disp];
    m_dval[k] = m_val[k][m_D[k]][addr_disp];
    if (m_clr[k] > 0) begin
      m_mem[k][m_W[k]][8 - m_clr[k]] = 0;
      m_val[k][m_W[k]][8 - m_clr[k]] = 1;
      m_clr[k]--;
    end else if (ready && we) begin
      m_mem[k][m_W[k]][addr_write] = int'(din);
      m_val[k][m_W[k]][addr_write] = 1;
    end
    m_rep[k] = 0;
    if (frame) begin
      if (m_pn[k] > 0) begin
        m_D[k] = m_pq[k][0];
        for (int i = 0; i < 3; i++) m_pq[k][i] = m_pq[k][i+1];
        m_pn[k]--;
      end else begin
        m_rep[k] = 1;
      end
    end
    if (ready && draw_done) begin
      m_pq[k][m_pn[k]] = m_W[k];
      m_pn[k]++;
      if (m_pn[k] <= nb - 2) start_draw(k);
      else m_wait[k] = 1;
    end else if (m_wait[k] && m_pn[k] <= nb - 2) begin
      m_wait[k] = 0;
      start_draw(k);
    end
  endtask

  task automatic check_inst(input int k);
    int eb, er;
    eb = (m_clr[k] > 0) ? 1 : 0;
    er = (m_clr[k] == 0 && !m_wait[k]) ? 1 : 0;
    if (k == 0) begin
      chk("u0_busy", int'(busy0), eb);
      chk("u0_ready", int'(rdy0), er);
      chk("u0_bufdraw", int'(bd0), m_W[0]);
      chk("u0_bufdisp", int'(bs0), m_D[0]);
      chk("u0_repeat", int'(rep0), int'(m_rep[0]));
      if (m_dval[0]) chk("u0_dout", int'(dout0), m_dout[0]);
    end else begin
      chk("u1_busy", int'(busy1), eb);
      chk("u1_ready", int'(rdy1), er);
      chk("u1_bufdraw", int'(bd1), m_W[1]);
      chk("u1_bufdisp", int'(bs1), m_D[1]);
      chk("u1_repeat", int'(rep1), int'(m_rep[1]));
      if (m_dval[1]) chk("u1_dout", int'(dout1), m_dout[1]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic pulse_dd();
    draw_done = 1'b1; tick(); draw_done = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (((k == 0) ? rdy0 : rdy1) !== 1'b1 && n < 30) begin
      tick(); n++;
    end
    if (n >= 30) chk("ready_timeout", k, -1);
  endtask

  task automatic busy_len(input string tag);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 30) begin
      tick(); n++;
    end
    chk(tag, n, CLRN);
  endtask

  initial begin
    int n;
    rst = 1'b1; frame = 1'b0; we = 1'b0; draw_done = 1'b0;
    addr_write = '0; addr_disp = '0; din = '0;
    tick(); tick();
    rst = 1'b0;

    busy_len("reset_busy_len");
    chk("reset_ready", int'(rdy0), 1);
    chk("reset_bufdraw", int'(bd0), 1);
    chk("reset_bufdisp", int'(bs0), 0);

    we = 1'b1; addr_write = 3'd3; din = 4'hB;
    tick();
    we = 1'b0;
    pulse_dd();
    chk("wait_ready0", int'(rdy0), 0);
    chk("wait_busy0", int'(busy0), 0);
    chk("nb3_bufdraw", int'(bd1), 2);
    chk("nb3_busy", int'(busy1), CLRN > 0 ? 1 : 0);
    tick(); tick();
    chk("still_wait0", int'(rdy0), 0);
    frame = 1'b1; addr_disp = 3'd3;
    tick();
    frame = 1'b0;
    chk("swap_bufdisp", int'(bs0), 1);
    chk("swap_bufdraw", int'(bd0), 0);
    chk("swap_busy", int'(busy0), CLRN > 0 ? 1 : 0);
    tick();
    chk("swap_dout", int'(dout0), 11);

    wait_ready(0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("repeat_pulse", int'(rep0), 1);
    chk("repeat_disp", int'(bs0), 1);
    chk("repeat_dout", int'(dout0), 11);
    tick();
    chk("repeat_one_cycle", int'(rep0), 0);

    wait_ready(0);
    wait_ready(1);
    pulse_dd();
    chk("nb3_dd1_bufdraw", int'(bd1), 0);
    chk("nb3_dd1_busy", int'(busy1), CLRN > 0 ? 1 : 0);
    wait_ready(1);
    pulse_dd();
    chk("nb3_dd2_ready", int'(rdy1), 0);
    chk("nb3_dd2_busy", int'(busy1), 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("nb3_frame_disp", int'(bs1), 2);
    chk("nb3_frame_draw", int'(bd1), 1);
    chk("nb3_frame_busy", int'(busy1), CLRN > 0 ? 1 : 0);

    wait_ready(0);
    frame = 1'b1; draw_done = 1'b1;
    tick();
    frame = 1'b0; draw_done = 1'b0;
    chk("same_cycle_repeat", int'(rep0), 1);
    chk("same_cycle_ready", int'(rdy0), 0);
    chk("same_cycle_busy", int'(busy0), 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("same_cycle_next_disp", int'(bs0), 1);

    n = 0;
    while (m_clr[0] != CLRN - 5 && n < 20) begin
      tick(); n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len("midclear_busy_len");
    chk("midclear_ready", int'(rdy0), 1);
    chk("midclear_bufdraw", int'(bd0), 1);

    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      we = $urandom_range(0, 1) == 1;
      addr_write = 3'($urandom_range(0, 7));
      din = 4'($urandom_range(0, 15));
      addr_disp = 3'($urandom_range(0, 7));
      frame = ($urandom_range(0, 7) == 0);
      draw_done = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0; frame = 1'b0; we = 1'b0; draw_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
